// File: rtl/pkg_cpu.sv
// Shared CPU definitions: datapath widths, flag positions, ALU opcodes and
// the operand/result bundles exchanged with the main and small ALUs.
package pkg_cpu;

  localparam int WORD_W     = 32;
  localparam int DATA_BUS_W = 48;
  localparam int NUM_FLAGS  = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_ORR = 4'd5,
    ALU_XOR = 4'd6,
    ALU_LSL = 4'd7,
    ALU_LSR = 4'd8,
    ALU_ASR = 4'd9,
    ALU_ROL = 4'd10,
    ALU_ROR = 4'd11,
    ALU_MUL = 4'd12,
    ALU_CMP = 4'd13,
    ALU_MOV = 4'd14,
    ALU_NOT = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic [WORD_W-1:0]    a;
    logic [WORD_W-1:0]    b;
    alu_op_e              oper;
    logic [NUM_FLAGS-1:0] flags;
  } StrcInAlu;

  typedef struct packed {
    logic [WORD_W-1:0]    result;
    logic [NUM_FLAGS-1:0] flags;
  } StrcOutAlu;

  typedef struct packed {
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              sub;
  } StrcInSmallAlu;

  typedef struct packed {
    logic [WORD_W-1:0] result;
  } StrcOutSmallAlu;

endpackage

// File: rtl/pkg_instr_enc.sv
// Instruction encoding: field positions inside the left-aligned 48-bit bus
// word and the decoded-instruction bundle.
package pkg_instr_enc;

  localparam int GRP_MSB = 47;
  localparam int GRP_LSB = 46;
  localparam int OPC_MSB = 45;
  localparam int OPC_LSB = 40;
  localparam int RA_MSB  = 39;
  localparam int RA_LSB  = 36;
  localparam int RB_MSB  = 35;
  localparam int RB_LSB  = 32;
  localparam int IMM16_MSB = 31;
  localparam int IMM16_LSB = 16;
  localparam int IMM32_MSB = 31;
  localparam int IMM32_LSB = 0;

  typedef struct packed {
    logic [1:0]  grp;
    logic [5:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] imm;
    logic [2:0]  len;
  } StrcOutInstrDecoder;

endpackage

// File: rtl/cpu_alu_core.sv
// Combinational 32-bit main ALU producing the result and {N,V,C,Z} flags.
module cpu_alu_core
  import pkg_cpu::*;
(
  input  logic [WORD_W-1:0]    a,
  input  logic [WORD_W-1:0]    b,
  input  logic [3:0]           oper,
  input  logic [NUM_FLAGS-1:0] flags_in,
  output logic [WORD_W-1:0]    result,
  output logic [NUM_FLAGS-1:0] flags_out
);

  alu_op_e     op;
  logic [4:0]  amt;
  logic        c_in;
  logic        add_cin;
  logic        sub_cin;
  logic [32:0] add_w;
  logic [32:0] sub_w;
  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [31:0] rol_w;
  logic [31:0] ror_w;
  logic        c_out;
  logic        v_out;

  always_comb begin
    op      = alu_op_e'(oper);
    amt     = b[4:0];
    c_in    = flags_in[FLAG_C];
    add_cin = (op == ALU_ADC) ? c_in : 1'b0;
    // Subtraction as a + ~b + cin so bit 32 is directly the no-borrow flag.
    sub_cin = (op == ALU_SBC) ? c_in : 1'b1;
    add_w   = {1'b0, a} + {1'b0, b} + {32'd0, add_cin};
    sub_w   = {1'b0, a} + {1'b0, ~b} + {32'd0, sub_cin};
    // Shifters carry one extra bit to catch the last bit shifted out.
    lsl_w   = {1'b0, a} << amt;
    lsr_w   = {a, 1'b0} >> amt;
    asr_w   = $signed({a, 1'b0}) >>> amt;
    rol_w   = (a << amt) | (a >> (6'd32 - {1'b0, amt}));
    ror_w   = (a >> amt) | (a << (6'd32 - {1'b0, amt}));

    result = add_w[31:0];
    c_out  = c_in;
    v_out  = flags_in[FLAG_V];
    case (op)
      ALU_ADD, ALU_ADC: begin
        result = add_w[31:0];
        c_out  = add_w[32];
        v_out  = (a[31] == b[31]) && (add_w[31] != a[31]);
      end
      ALU_SUB, ALU_SBC, ALU_CMP: begin
        result = sub_w[31:0];
        c_out  = sub_w[32];
        v_out  = (a[31] != b[31]) && (sub_w[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_ORR: result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_LSL: begin
        result = lsl_w[31:0];
        if (amt != 5'd0) c_out = lsl_w[32];
      end
      ALU_LSR: begin
        result = lsr_w[32:1];
        if (amt != 5'd0) c_out = lsr_w[0];
      end
      ALU_ASR: begin
        result = asr_w[32:1];
        if (amt != 5'd0) c_out = asr_w[0];
      end
      ALU_ROL: begin
        result = rol_w;
        if (amt != 5'd0) c_out = rol_w[0];
      end
      ALU_ROR: begin
        result = ror_w;
        if (amt != 5'd0) c_out = ror_w[31];
      end
      ALU_MUL: result = a * b;
      ALU_MOV: result = b;
      ALU_NOT: result = ~b;
      default: result = add_w[31:0];
    endcase

    flags_out         = '0;
    flags_out[FLAG_N] = result[31];
    flags_out[FLAG_V] = v_out;
    flags_out[FLAG_C] = c_out;
    flags_out[FLAG_Z] = (result == 32'd0);
  end

endmodule

// File: rtl/cpu_decode_alu_unit.sv
// Registered execute front-end: instruction decoder, main ALU and small
// address ALU, all captured together in a single output register stage.
module cpu_decode_alu_unit
  import pkg_cpu::*;
  import pkg_instr_enc::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_BUS_W-1:0] instr_in,
  input  logic [WORD_W-1:0]     alu_a,
  input  logic [WORD_W-1:0]     alu_b,
  input  logic [3:0]            alu_oper,
  input  logic [NUM_FLAGS-1:0]  alu_flags_in,
  input  logic [WORD_W-1:0]     salu_a,
  input  logic [WORD_W-1:0]     salu_b,
  input  logic                  salu_sub,
  output logic [1:0]            dec_group,
  output logic [5:0]            dec_opcode,
  output logic [3:0]            dec_ra,
  output logic [3:0]            dec_rb,
  output logic [WORD_W-1:0]     dec_imm,
  output logic [2:0]            dec_len,
  output logic [WORD_W-1:0]     alu_result,
  output logic [NUM_FLAGS-1:0]  alu_flags_out,
  output logic [WORD_W-1:0]     salu_result,
  output logic                  valid
);

  StrcInAlu             alu_in;
  StrcOutAlu            alu_d, alu_q;
  StrcInSmallAlu        salu_in;
  StrcOutSmallAlu       salu_d, salu_q;
  StrcOutInstrDecoder   dec_d, dec_q;
  logic                 valid_q;
  logic [WORD_W-1:0]    core_result;
  logic [NUM_FLAGS-1:0] core_flags;

  always_comb begin
    alu_in.a     = alu_a;
    alu_in.b     = alu_b;
    alu_in.oper  = alu_op_e'(alu_oper);
    alu_in.flags = alu_flags_in;
    salu_in.a    = salu_a;
    salu_in.b    = salu_b;
    salu_in.sub  = salu_sub;
  end

  cpu_alu_core u_alu_core (
    .a         (alu_in.a),
    .b         (alu_in.b),
    .oper      (alu_in.oper),
    .flags_in  (alu_in.flags),
    .result    (core_result),
    .flags_out (core_flags)
  );

  always_comb begin
    alu_d.result  = core_result;
    alu_d.flags   = core_flags;
    salu_d.result = salu_in.sub ? (salu_in.a - salu_in.b) : (salu_in.a + salu_in.b);
  end

  always_comb begin
    dec_d        = '0;
    dec_d.grp    = instr_in[GRP_MSB:GRP_LSB];
    dec_d.opcode = instr_in[OPC_MSB:OPC_LSB];
    dec_d.ra     = instr_in[RA_MSB:RA_LSB];
    dec_d.rb     = instr_in[RB_MSB:RB_LSB];
    case (dec_d.grp)
      2'd0: begin
        dec_d.len = 3'd2;
        dec_d.imm = 32'd0;
      end
      2'd1: begin
        dec_d.len = 3'd4;
        dec_d.imm = {{16{instr_in[IMM16_MSB]}}, instr_in[IMM16_MSB:IMM16_LSB]};
      end
      2'd2: begin
        dec_d.len = 3'd4;
        dec_d.imm = {16'd0, instr_in[IMM16_MSB:IMM16_LSB]};
      end
      default: begin
        dec_d.len = 3'd6;
        dec_d.imm = instr_in[IMM32_MSB:IMM32_LSB];
      end
    endcase
  end

  // A stalled edge keeps the data but drops valid, so consumers see each result once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q   <= '0;
      alu_q   <= '0;
      salu_q  <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      dec_q   <= dec_d;
      alu_q   <= alu_d;
      salu_q  <= salu_d;
      valid_q <= 1'b1;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign dec_group     = dec_q.grp;
  assign dec_opcode    = dec_q.opcode;
  assign dec_ra        = dec_q.ra;
  assign dec_rb        = dec_q.rb;
  assign dec_imm       = dec_q.imm;
  assign dec_len       = dec_q.len;
  assign alu_result    = alu_q.result;
  assign alu_flags_out = alu_q.flags;
  assign salu_result   = salu_q.result;
  assign valid         = valid_q;

endmodule

// File: tb/tb_cpu_decode_alu_unit.sv
// Bench for cpu_decode_alu_unit: directed corner cases plus randomized
// traffic checked against an arithmetic reference model.
module tb_cpu_decode_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [47:0] instr_in;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_oper;
  logic [3:0]  alu_flags_in;
  logic [31:0] salu_a, salu_b;
  logic        salu_sub;
  logic [1:0]  dec_group;
  logic [5:0]  dec_opcode;
  logic [3:0]  dec_ra, dec_rb;
  logic [31:0] dec_imm;
  logic [2:0]  dec_len;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags_out;
  logic [31:0] salu_result;
  logic        valid;

  int checks = 0;
  int failures = 0;

  cpu_decode_alu_unit dut (
    .clk(clk), .rst(rst), .en(en), .instr_in(instr_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper), .alu_flags_in(alu_flags_in),
    .salu_a(salu_a), .salu_b(salu_b), .salu_sub(salu_sub),
    .dec_group(dec_group), .dec_opcode(dec_opcode), .dec_ra(dec_ra), .dec_rb(dec_rb),
    .dec_imm(dec_imm), .dec_len(dec_len), .alu_result(alu_result),
    .alu_flags_out(alu_flags_out), .salu_result(salu_result), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  // Returns {N,V,C,Z,result}, derived from the operation definitions with wide arithmetic.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [3:0] fl);
    longint unsigned ua, ub, u, cin;
    longint          sa, sb, s;
    logic [31:0]     r;
    logic            c, v;
    int              sh;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    c  = fl[1];
    v  = fl[2];
    r  = 32'd0;
    case (op)
      4'd0, 4'd1: begin
        cin = (op == 4'd1 && fl[1]) ? 64'd1 : 64'd0;
        u = ua + ub + cin;
        r = u[31:0];
        c = (u > 64'h0000_0000_FFFF_FFFF);
        s = sa + sb + longint'(cin);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2, 4'd3, 4'd13: begin
        cin = (op == 4'd3 && !fl[1]) ? 64'd1 : 64'd0;
        u = ua - ub - cin;
        r = u[31:0];
        c = (ua >= ub + cin);
        s = sa - sb - longint'(cin);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = a ^ b;
      4'd7: begin r = a << sh; if (sh != 0) c = a[32-sh]; end
      4'd8: begin r = a >> sh; if (sh != 0) c = a[sh-1]; end
      4'd9: begin
        s = sa >>> sh;
        r = s[31:0];
        if (sh != 0) c = a[sh-1];
      end
      4'd10: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[31]; r = {r[30:0], r[31]}; end
      end
      4'd11: begin
        r = a;
        for (int i = 0; i < sh; i++) begin c = r[0]; r = {r[0], r[31:1]}; end
      end
      4'd12: begin u = ua * ub; r = u[31:0]; end
      4'd14: r = b;
      default: r = ~b;
    endcase
    return {r[31], v, c, (r == 32'd0), r};
  endfunction

  // Returns {group, opcode, ra, rb, imm, len}.
  function automatic logic [50:0] ref_dec(input logic [47:0] ins);
    logic [1:0]  g;
    logic [31:0] imm;
    logic [2:0]  len;
    int          sx;
    g = ins[47:46];
    sx = int'($signed(ins[31:16]));
    case (g)
      2'd0:    begin imm = 32'd0;              len = 3'd2; end
      2'd1:    begin imm = 32'(sx);            len = 3'd4; end
      2'd2:    begin imm = {16'd0, ins[31:16]}; len = 3'd4; end
      default: begin imm = ins[31:0];          len = 3'd6; end
    endcase
    return {g, ins[45:40], ins[39:36], ins[35:32], imm, len};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; instr_in = 48'hFFFF_FFFF_FFFF;
    alu_a = 32'h1234; alu_b = 32'h1; alu_oper = 4'd0; alu_flags_in = 4'h0;
    salu_a = 32'h10; salu_b = 32'h20; salu_sub = 1'b0;
    #1;
    checks++;
    if ({dec_group, dec_opcode, dec_ra, dec_rb, dec_imm, dec_len, alu_result, alu_flags_out, salu_result, valid} !== '0) begin
      failures++;
      $display("FAIL reset_initial got alu=%h sal=%h valid=%b want all zero", alu_result, salu_result, valid);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b1 || alu_result !== 32'h1235 || salu_result !== 32'h30) begin
      failures++;
      $display("FAIL reset_release got valid=%b alu=%h sal=%h want 1 00001235 00000030", valid, alu_result, salu_result);
    end
    // Asynchronous assertion between edges, with en still high.
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({alu_result, alu_flags_out, salu_result, dec_imm, dec_len, valid} !== '0) begin
      failures++;
      $display("FAIL reset_async got alu=%h sal=%h valid=%b want all zero", alu_result, salu_result, valid);
    end
    tick();
    rst = 1'b0;
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_held got valid=%b want 0", valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || alu_result !== 32'h1235 || dec_len !== 3'd6) begin
      failures++;
      $display("FAIL reset_resume got valid=%b alu=%h len=%0d want 1 00001235 6", valid, alu_result, dec_len);
    end
  endtask

  logic [107:0] alu_vec [0:13];

  task automatic test_alu_directed();
    // {op, a, b, flags_in, result, flags_out}
    alu_vec = '{
      {4'd0,  32'hFFFFFFFF, 32'h00000001, 4'h0, 32'h00000000, 4'h3},
      {4'd0,  32'h7FFFFFFF, 32'h00000001, 4'h0, 32'h80000000, 4'hC},
      {4'd2,  32'h00000005, 32'h00000005, 4'h0, 32'h00000000, 4'h3},
      {4'd2,  32'h00000003, 32'h00000005, 4'h0, 32'hFFFFFFFE, 4'h8},
      {4'd3,  32'h0000000A, 32'h00000003, 4'h0, 32'h00000006, 4'h2},
      {4'd7,  32'h80000001, 32'h00000001, 4'h0, 32'h00000002, 4'h2},
      {4'd9,  32'h80000000, 32'h0000001F, 4'h0, 32'hFFFFFFFF, 4'h8},
      {4'd8,  32'h12345678, 32'h00000000, 4'h2, 32'h12345678, 4'h2},
      {4'd11, 32'h00000001, 32'h00000001, 4'h0, 32'h80000000, 4'hA},
      {4'd13, 32'h00000005, 32'h00000007, 4'h0, 32'hFFFFFFFE, 4'h8},
      {4'd14, 32'hDEADBEEF, 32'h00000000, 4'h6, 32'h00000000, 4'h7},
      {4'd15, 32'h00000000, 32'h00000000, 4'h0, 32'hFFFFFFFF, 4'h8},
      {4'd12, 32'h00010000, 32'h00010000, 4'h6, 32'h00000000, 4'h7},
      {4'd1,  32'h00000001, 32'h00000001, 4'h2, 32'h00000003, 4'h0}
    };
    en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      {alu_oper, alu_a, alu_b, alu_flags_in} = alu_vec[i][107:36];
      tick();
      checks++;
      if (alu_result !== alu_vec[i][35:4] || alu_flags_out !== alu_vec[i][3:0]) begin
        failures++;
        $display("FAIL alu_vec%0d op=%0d got res=%h fl=%h want res=%h fl=%h", i, alu_oper,
                 alu_result, alu_flags_out, alu_vec[i][35:4], alu_vec[i][3:0]);
      end
    end
  endtask

  task automatic test_decode();
    logic [47:0] ins [0:3];
    logic [50:0] want [0:3];
    ins[0]  = 48'h7A5C_8000_0000;
    want[0] = {2'd1, 6'h3A, 4'h5, 4'hC, 32'hFFFF8000, 3'd4};
    ins[1]  = {2'b11, 6'h01, 4'h2, 4'h3, 32'h12345678};
    want[1] = {2'd3, 6'h01, 4'h2, 4'h3, 32'h12345678, 3'd6};
    ins[2]  = {2'b10, 6'h15, 4'hF, 4'h0, 32'h8000_ABCD};
    want[2] = {2'd2, 6'h15, 4'hF, 4'h0, 32'h00008000, 3'd4};
    ins[3]  = {2'b00, 6'h3F, 4'h9, 4'h7, 32'hFFFF_FFFF};
    want[3] = {2'd0, 6'h3F, 4'h9, 4'h7, 32'h00000000, 3'd2};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_in = ins[i];
      tick();
      checks++;
      if ({dec_group, dec_opcode, dec_ra, dec_rb, dec_imm, dec_len} !== want[i]) begin
        failures++;
        $display("FAIL decode%0d got grp=%0d opc=%h ra=%h rb=%h imm=%h len=%0d want %h", i,
                 dec_group, dec_opcode, dec_ra, dec_rb, dec_imm, dec_len, want[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_res, held_sal, held_imm;
    en = 1'b1; alu_a = 32'd100; alu_b = 32'd23; alu_oper = 4'd2; alu_flags_in = 4'h0;
    salu_a = 32'h40; salu_b = 32'h4; salu_sub = 1'b1; instr_in = 48'hC000_CAFE_F00D;
    tick();
    held_res = 32'd77; held_sal = 32'h3C; held_imm = 32'hCAFEF00D;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_a = $urandom; alu_b = $urandom; alu_oper = 4'($urandom);
      salu_a = $urandom; instr_in = {$urandom, 16'($urandom)};
      tick();
      checks++;
      if (valid !== 1'b0 || alu_result !== held_res || salu_result !== held_sal || dec_imm !== held_imm) begin
        failures++;
        $display("FAIL stall%0d got valid=%b alu=%h sal=%h imm=%h want 0 %h %h %h", i,
                 valid, alu_result, salu_result, dec_imm, held_res, held_sal, held_imm);
      end
    end
  endtask

  task automatic test_small_alu();
    en = 1'b1;
    salu_a = 32'hFFFFFFFE; salu_b = 32'd6; salu_sub = 1'b0;
    tick();
    checks++;
    if (salu_result !== 32'h00000004 || valid !== 1'b1) begin
      failures++;
      $display("FAIL salu_add_wrap got %h valid=%b want 00000004 1", salu_result, valid);
    end
    salu_a = 32'd3; salu_b = 32'd5; salu_sub = 1'b1;
    tick();
    checks++;
    if (salu_result !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL salu_sub_wrap got %h want fffffffe", salu_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] exp_alu;
    logic [50:0] exp_dec;
    logic [31:0] exp_sal;
    logic        exp_valid;
    exp_alu = {alu_flags_out, alu_result};
    exp_dec = {dec_group, dec_opcode, dec_ra, dec_rb, dec_imm, dec_len};
    exp_sal = salu_result;
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 4) != 0);
      alu_oper = 4'($urandom);
      alu_a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      alu_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 33)) : $urandom;
      alu_flags_in = 4'($urandom);
      salu_a = $urandom; salu_b = $urandom; salu_sub = 1'($urandom);
      instr_in = {$urandom, 16'($urandom)};
      if (en) begin
        exp_alu = ref_alu(alu_a, alu_b, alu_oper, alu_flags_in);
        exp_dec = ref_dec(instr_in);
        exp_sal = salu_sub ? salu_a - salu_b : salu_a + salu_b;
      end
      exp_valid = en;
      tick();
      checks++;
      if ({alu_flags_out, alu_result} !== exp_alu || valid !== exp_valid) begin
        failures++;
        $display("FAIL rand_alu%0d op=%0d got fl=%h res=%h v=%b want fl=%h res=%h v=%b", i, alu_oper,
                 alu_flags_out, alu_result, valid, exp_alu[35:32], exp_alu[31:0], exp_valid);
      end
      checks++;
      if ({dec_group, dec_opcode, dec_ra, dec_rb, dec_imm, dec_len} !== exp_dec || salu_result !== exp_sal) begin
        failures++;
        $display("FAIL rand_dec%0d got imm=%h len=%0d sal=%h want imm=%h len=%0d sal=%h", i,
                 dec_imm, dec_len, salu_result, exp_dec[34:3], exp_dec[2:0], exp_sal);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_decode();
    test_stall();
    test_small_alu();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
